// File: rtl/l2_mem_arbiter.sv
// Main-memory port sequencer below the L2: arbitrates line-fill reads against
// eviction write-buffer drains and moves each 256-bit line as four 64-bit beats.
module l2_mem_arbiter #(
   parameter int READ_PRIO_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         fill_read_i,
   input  logic [31:0]  fill_addr_i,
   output logic         fill_resp_o,
   output logic [255:0] fill_rdata_o,
   input  logic         ewb_empty_i,
   input  logic         ewb_full_i,
   input  logic [255:0] ewb_data_i,
   input  logic [31:0]  ewb_addr_i,
   output logic         ewb_yumi_o,
   output logic [31:0]  bmem_addr_o,
   output logic         bmem_read_o,
   output logic         bmem_write_o,
   output logic [63:0]  bmem_wdata_o,
   input  logic         bmem_ready_i,
   input  logic         bmem_rvalid_i,
   input  logic [63:0]  bmem_rdata_i
);

   localparam int SW = $clog2(READ_PRIO_MAX + 1);

   typedef enum logic [2:0] {IDLE, WR_BURST, RD_REQ, RD_WAIT, RD_RESP} state_t;

   state_t         state;
   logic [SW-1:0]  streak;
   logic [1:0]     beat;
   logic [255:0]   wr_line;
   logic [31:0]    line_addr;
   logic           wr_grant;
   logic           rd_grant;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^{fill_addr_i[4:0], ewb_addr_i[4:0]};

   // A full EWB pre-empts reads outright; otherwise reads win until the streak
   // limit is reached while writes are waiting.
   always_comb begin
      wr_grant = 1'b0;
      rd_grant = 1'b0;
      if (state == IDLE && !rst) begin
         if (ewb_full_i && !ewb_empty_i)
            wr_grant = 1'b1;
         else if (fill_read_i && (streak < SW'(READ_PRIO_MAX)))
            rd_grant = 1'b1;
         else if (!ewb_empty_i)
            wr_grant = 1'b1;
         else if (fill_read_i)
            rd_grant = 1'b1;
      end
   end

   assign ewb_yumi_o   = wr_grant;
   assign bmem_write_o = (state == WR_BURST);
   assign bmem_read_o  = (state == RD_REQ);
   assign fill_resp_o  = (state == RD_RESP);
   assign bmem_addr_o  = line_addr;

   always_comb begin
      bmem_wdata_o = 64'd0;
      if (state == WR_BURST)
         bmem_wdata_o = wr_line[{beat, 6'd0} +: 64];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         streak       <= '0;
         beat         <= 2'd0;
         wr_line      <= 256'd0;
         line_addr    <= 32'd0;
         fill_rdata_o <= 256'd0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_grant) begin
                  wr_line   <= ewb_data_i;
                  line_addr <= {ewb_addr_i[31:5], 5'd0};
                  streak    <= '0;
                  beat      <= 2'd0;
                  state     <= WR_BURST;
               end else if (rd_grant) begin
                  line_addr <= {fill_addr_i[31:5], 5'd0};
                  beat      <= 2'd0;
                  state     <= RD_REQ;
                  if (ewb_empty_i)
                     streak <= '0;
                  else if (streak < SW'(READ_PRIO_MAX))
                     streak <= streak + SW'(1);
               end
            end
            WR_BURST: begin
               if (bmem_ready_i) begin
                  beat <= beat + 2'd1;
                  if (beat == 2'd3)
                     state <= IDLE;
               end
            end
            RD_REQ: begin
               if (bmem_ready_i)
                  state <= RD_WAIT;
            end
            RD_WAIT: begin
               if (bmem_rvalid_i) begin
                  fill_rdata_o[{beat, 6'd0} +: 64] <= bmem_rdata_i;
                  beat <= beat + 2'd1;
                  if (beat == 2'd3)
                     state <= RD_RESP;
               end
            end
            RD_RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench for l2_mem_arbiter: EWB, fill requester and memory models
// drive the DUT while a negedge monitor checks every beat and response.
module tb_l2_mem_arbiter;

   typedef struct {
      logic [31:0]  addr;
      logic [255:0] data;
   } line_t;

   localparam byte GW = 8'd87;
   localparam byte GR = 8'd82;

   logic         clk = 1'b0;
   logic         rst;
   logic         fill_read;
   logic [31:0]  fill_addr;
   logic         fill_resp;
   logic [255:0] fill_rdata;
   logic         ewb_empty;
   logic         ewb_full;
   logic [255:0] ewb_data;
   logic [31:0]  ewb_addr;
   logic         ewb_yumi;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic         bmem_rvalid;
   logic [63:0]  bmem_rdata;

   l2_mem_arbiter #(.READ_PRIO_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .fill_read_i(fill_read), .fill_addr_i(fill_addr),
      .fill_resp_o(fill_resp), .fill_rdata_o(fill_rdata),
      .ewb_empty_i(ewb_empty), .ewb_full_i(ewb_full),
      .ewb_data_i(ewb_data), .ewb_addr_i(ewb_addr), .ewb_yumi_o(ewb_yumi),
      .bmem_addr_o(bmem_addr), .bmem_read_o(bmem_read), .bmem_write_o(bmem_write),
      .bmem_wdata_o(bmem_wdata), .bmem_ready_i(bmem_ready),
      .bmem_rvalid_i(bmem_rvalid), .bmem_rdata_i(bmem_rdata)
   );

   always #5 clk = ~clk;

   line_t        ewbQ[$];
   line_t        expWrQ[$];
   logic [255:0] expRdQ[$];
   logic [31:0]  expAddrQ[$];
   logic [31:0]  fillQ[$];
   byte          grantLog[$];
   byte          modelLog[$];
   int           beatCycles[$];

   int checks = 0, failures = 0;
   int cycle = 0;
   int yumiCnt = 0, popCnt = 0, rdAcceptCnt = 0, rdServedCnt = 0, respCnt = 0, respSeen = 0;
   int fullLevel = 4, readyMode = 0, stallLeft = 0, rvGapMin = 0, rvGapMax = 0;
   int wrBeat = 0, wrCycles = 0, readCycles = 0, yumiCycle = 0, rvBeat = 0, lastRvCycle = 0;
   int rStreak = 0, beatsLeft = 0;
   bit wrActive = 0, inReset = 1, strayRv = 0, rvReal = 0;
   bit prevRead = 0, prevEmpty = 1, prevFill = 0, prevResp = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_read"}, bmem_read, 0);
      checkOutput({tag, "_write"}, bmem_write, 0);
      checkOutput({tag, "_wdata"}, bmem_wdata, 0);
      checkOutput({tag, "_addr"}, bmem_addr, 0);
      checkOutput({tag, "_yumi"}, ewb_yumi, 0);
      checkOutput({tag, "_resp"}, fill_resp, 0);
      checkOutput({tag, "_rdata"}, fill_rdata, 0);
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [255:0] data);
      line_t l;
      l.addr = addr;
      l.data = data;
      ewbQ.push_back(l);
      l.addr = {addr[31:5], 5'd0};
      expWrQ.push_back(l);
   endtask

   function automatic logic [255:0] randLine();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Grant order implied by the priority rules when all requests are present
   // up front and fills are re-issued back to back.
   function automatic void buildModel(input int nReads, input int nLines, input int full);
      int s = 0;
      modelLog.delete();
      while (nReads > 0 || nLines > 0) begin
         if (nLines > 0 && nLines >= full) begin
            modelLog.push_back(GW); nLines--; s = 0;
         end else if (nReads > 0 && s < 4) begin
            modelLog.push_back(GR); nReads--; s = (nLines > 0) ? s + 1 : 0;
         end else if (nLines > 0) begin
            modelLog.push_back(GW); nLines--; s = 0;
         end else begin
            modelLog.push_back(GR); nReads--; s = 0;
         end
      end
   endfunction

   task automatic compareGrants(input string tag);
      checkOutput({tag, "_grant_count"}, grantLog.size(), modelLog.size());
      for (int i = 0; i < modelLog.size() && i < grantLog.size(); i++)
         checkOutput($sformatf("%s_grant%0d", tag, i), grantLog[i], modelLog[i]);
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n = 0;
      while (n < budget) begin
         @(negedge clk); #3;
         if (expWrQ.size() == 0 && expRdQ.size() == 0 && fillQ.size() == 0 &&
             expAddrQ.size() == 0 && ewbQ.size() == 0 && !fill_read &&
             rdAcceptCnt == rdServedCnt && beatsLeft == 0 && !bmem_read && !bmem_write)
            break;
         n++;
      end
      if (n >= budget) checkOutput({tag, "_drain_timeout"}, 1, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic doReset(input string tag);
      @(posedge clk); #1;
      rst = 1'b1;
      inReset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkAllZero(tag);
      @(posedge clk); #1;
      rst = 1'b0;
      if (wrActive) void'(expWrQ.pop_front());
      wrActive = 0; wrBeat = 0; rStreak = 0; prevRead = 0;
      inReset = 1'b0;
   endtask

   // EWB model: head line presented, popped on the edge after a sampled yumi.
   initial begin
      ewb_empty = 1'b1; ewb_full = 1'b0; ewb_data = '1; ewb_addr = '1;
      forever begin
         @(posedge clk); #1;
         if (yumiCnt > popCnt) begin
            void'(ewbQ.pop_front());
            popCnt++;
         end
         ewb_empty = (ewbQ.size() == 0);
         ewb_full  = (ewbQ.size() >= fullLevel);
         if (ewbQ.size() > 0) begin
            ewb_data = ewbQ[0].data;
            ewb_addr = ewbQ[0].addr;
         end else begin
            ewb_data = '1;
            ewb_addr = '1;
         end
      end
   end

   // Fill requester: holds the request until the response, then re-issues.
   initial begin
      fill_read = 1'b0; fill_addr = 32'd0;
      forever begin
         @(posedge clk); #1;
         if (fill_read && respCnt > respSeen) begin
            respSeen = respCnt;
            if (fillQ.size() > 0) begin
               fill_addr = fillQ.pop_front();
               expAddrQ.push_back({fill_addr[31:5], 5'd0});
            end else fill_read = 1'b0;
         end else if (!fill_read && fillQ.size() > 0) begin
            fill_read = 1'b1;
            fill_addr = fillQ.pop_front();
            expAddrQ.push_back({fill_addr[31:5], 5'd0});
         end
      end
   end

   // Memory model: ready policy, read beats with gaps, optional stray rvalid.
   initial begin
      logic [255:0] rdLine;
      int gap;
      bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = 64'd0;
      gap = 0; rdLine = '0;
      forever begin
         @(posedge clk); #1;
         bmem_rvalid = 1'b0;
         rvReal = 1'b0;
         bmem_rdata = {$urandom, $urandom};
         if (beatsLeft > 0) begin
            if (gap == 0) begin
               bmem_rvalid = 1'b1;
               rvReal = 1'b1;
               bmem_rdata = rdLine[(4 - beatsLeft)*64 +: 64];
               beatsLeft--;
               gap = $urandom_range(rvGapMax, rvGapMin);
            end else gap--;
         end else if (rdAcceptCnt > rdServedCnt) begin
            rdServedCnt++;
            rdLine = randLine();
            expRdQ.push_back(rdLine);
            beatsLeft = 4;
            gap = $urandom_range(rvGapMax, rvGapMin);
         end else if (strayRv && $urandom_range(0, 5) == 0) begin
            bmem_rvalid = 1'b1;
         end
         case (readyMode)
            0: bmem_ready = 1'b1;
            1: bmem_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (bmem_write && wrBeat == 2 && stallLeft > 0) begin
                  bmem_ready = 1'b0;
                  stallLeft--;
               end else bmem_ready = 1'b1;
            end
         endcase
      end
   end

   // Monitor: pops the scoreboards whenever the DUT presents a beat or response.
   always @(negedge clk) begin
      if (!inReset) begin
         assert (!(prevFill && !fill_read && !prevResp))
            else $error("[TB] FAIL fill_read_drop: request withdrawn before response");
         if (bmem_write) begin
            wrCycles++;
            if (expWrQ.size() == 0) checkOutput("wr_unexpected", bmem_write, 0);
            else begin
               checkOutput("wr_addr", bmem_addr, expWrQ[0].addr);
               checkOutput("wr_data", bmem_wdata, expWrQ[0].data[wrBeat*64 +: 64]);
               if (bmem_ready) begin
                  beatCycles.push_back(cycle);
                  wrBeat++;
                  if (wrBeat == 4) begin
                     void'(expWrQ.pop_front());
                     wrBeat = 0;
                     wrActive = 0;
                  end
               end
            end
         end else checkOutput("wdata_idle", bmem_wdata, 0);
         if (ewb_yumi) begin
            yumiCnt++;
            wrActive = 1;
            grantLog.push_back(GW);
            yumiCycle = cycle;
            beatCycles.delete();
            wrCycles = 0;
            rStreak = 0;
         end
         if (bmem_read) readCycles++;
         if (bmem_read && !prevRead) begin
            grantLog.push_back(GR);
            readCycles = 1;
            if (!prevEmpty) begin
               rStreak++;
               checkOutput("read_streak_bound", (rStreak > 4), 0);
            end else rStreak = 0;
         end
         if (bmem_read && bmem_ready) begin
            rdAcceptCnt++;
            rvBeat = 0;
            if (expAddrQ.size() == 0) checkOutput("rd_unexpected", bmem_read, 0);
            else checkOutput("rd_addr", bmem_addr, expAddrQ.pop_front());
         end
         if (bmem_rvalid && rvReal) begin
            rvBeat++;
            if (rvBeat == 4) lastRvCycle = cycle;
         end
         if (fill_resp) begin
            respCnt++;
            if (expRdQ.size() == 0) checkOutput("resp_unexpected", fill_resp, 0);
            else begin
               checkOutput("fill_data", fill_rdata, expRdQ.pop_front());
               checkOutput("resp_latency", cycle - lastRvCycle, 1);
            end
         end
         prevRead  = bmem_read;
         prevEmpty = ewb_empty;
         prevFill  = fill_read;
         prevResp  = fill_resp;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [255:0] pat;
      int n;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checkAllZero("idle");
      end
      inReset = 1'b0;

      $display("[TB] zero-stall write burst");
      for (int k = 0; k < 32; k++) pat[k*8 +: 8] = 8'(k);
      @(negedge clk); #2;
      applyStimulus(32'h0000_1234, pat);
      waitDrain("write", 200);
      checkOutput("write_beat_count", beatCycles.size(), 4);
      for (int i = 0; i < 4 && i < beatCycles.size(); i++)
         checkOutput($sformatf("write_beat%0d_cycle", i), beatCycles[i] - yumiCycle, i + 1);

      $display("[TB] fill with spaced beats");
      rvGapMin = 2; rvGapMax = 2;
      @(negedge clk); #2;
      fillQ.push_back(32'h0000_8000);
      waitDrain("fill", 200);
      checkOutput("fill_request_cycles", readCycles, 1);
      rvGapMin = 0; rvGapMax = 1;

      $display("[TB] bounded read priority");
      fullLevel = 8;
      grantLog.delete();
      @(negedge clk); #2;
      for (int i = 0; i < 3; i++) applyStimulus($urandom, randLine());
      for (int i = 0; i < 10; i++) fillQ.push_back($urandom);
      waitDrain("streak", 3000);
      buildModel(10, 3, 8);
      compareGrants("streak");

      $display("[TB] full EWB beats pending fill");
      fullLevel = 2;
      grantLog.delete();
      @(negedge clk); #2;
      for (int i = 0; i < 3; i++) applyStimulus($urandom, randLine());
      for (int i = 0; i < 2; i++) fillQ.push_back($urandom);
      waitDrain("full", 2000);
      buildModel(2, 3, 2);
      compareGrants("full");

      $display("[TB] write stall on beat 2");
      fullLevel = 4; readyMode = 2; stallLeft = 3;
      @(negedge clk); #2;
      applyStimulus(32'hABCD_0040, randLine());
      waitDrain("stall", 200);
      checkOutput("stall_write_cycles", wrCycles, 7);
      checkOutput("stall_beat_count", beatCycles.size(), 4);

      $display("[TB] reset during write burst");
      stallLeft = 1000;
      @(negedge clk); #2;
      applyStimulus(32'h5555_0000, randLine());
      n = 0;
      while (n < 100) begin
         @(negedge clk); #1;
         if (bmem_write && wrBeat == 2) break;
         n++;
      end
      if (n >= 100) checkOutput("midburst_wait_timeout", 1, 0);
      doReset("rst_mid");
      stallLeft = 0; readyMode = 0;
      waitDrain("after_reset", 200);

      $display("[TB] randomized traffic");
      readyMode = 1; strayRv = 1; rvGapMin = 0; rvGapMax = 3; fullLevel = 4;
      repeat (600) begin
         @(negedge clk); #2;
         if ($urandom_range(0, 9) == 0 && ewbQ.size() < 6) applyStimulus($urandom, randLine());
         if ($urandom_range(0, 11) == 0 && fillQ.size() < 3) fillQ.push_back($urandom);
      end
      waitDrain("random", 8000);
      strayRv = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Sequences the single main-memory port below the L2 cache between line-fill reads on an L2 miss and drain writes from the eviction write buffer (EWB). It selects one 256-bit transaction at a time and moves it as a 4-beat, 64-bit burst. It owns the EWB dequeue handshake and enforces a bounded read-over-write priority so the EWB can never starve.

## Interface
- READ_PRIO_MAX, 4: max consecutive read grants while the EWB is non-empty before a write is forced.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fill_read_i  in  1  L2 miss fill request; held high until fill_resp_o
- fill_addr_i  in  32  fill address; bits [4:0] ignored
- fill_resp_o  out  1  one-cycle pulse: fill_rdata_o valid
- fill_rdata_o  out  256  assembled fill line
- ewb_empty_i  in  1  EWB empty
- ewb_full_i  in  1  EWB full
- ewb_data_i  in  256  EWB head line
- ewb_addr_i  in  32  EWB head address
- ewb_yumi_o  out  1  dequeue EWB head (one-cycle pulse)
- bmem_addr_o  out  32  line address, {addr[31:5],5'b0}
- bmem_read_o  out  1  read request
- bmem_write_o  out  1  write beat valid
- bmem_wdata_o  out  64  write beat data
- bmem_ready_i  in  1  memory accepts request/beat this cycle
- bmem_rvalid_i  in  1  read beat valid
- bmem_rdata_i  in  64  read beat data

## Operation
- States: IDLE, WR_BURST, RD_REQ, RD_WAIT, RD_RESP.
- IDLE grant priority, evaluated every cycle:
  1. ewb_full_i and !ewb_empty_i -> write.
  2. Else, fill_read_i and streak < READ_PRIO_MAX -> read.
  3. Else, !ewb_empty_i -> write.
  4. Else, fill_read_i -> read.
- streak counter (saturating):
  - +1 on each read grant while ewb_empty_i=0.
  - Cleared on any write grant.
  - Cleared on a read grant while ewb_empty_i=1.
- Write grant:
  - Latch ewb_data_i and aligned ewb_addr_i into internal registers.
  - Pulse ewb_yumi_o in the grant cycle. Later changes to the EWB head do not affect the burst.
  - Go to WR_BURST, beat=0.
- WR_BURST:
  - bmem_write_o=1; bmem_addr_o = latched address; bmem_wdata_o = line[64*beat+63:64*beat].
  - beat increments on each cycle with bmem_ready_i=1. Without ready, the beat is held.
  - After beat 3 is accepted -> IDLE.
- Read grant: latch the aligned fill_addr_i, then go to RD_REQ.
- RD_REQ: bmem_read_o=1 until a cycle with bmem_ready_i=1, then RD_WAIT.
- RD_WAIT:
  - Each bmem_rvalid_i beat k (k=0..3) is written to fill_rdata_o[64k+63:64k].
  - After beat 3 -> RD_RESP.
  - bmem_rvalid_i outside RD_WAIT is ignored.
- RD_RESP: fill_resp_o=1 for one cycle -> IDLE.
- Only one transaction is outstanding, so a fill read issued after a write to the same line observes the written data.
- Outputs outside their states are 0: bmem_read_o, bmem_write_o, ewb_yumi_o, fill_resp_o. bmem_wdata_o = 0 outside WR_BURST. fill_rdata_o holds its last line.

## Timing
- Reset values:
  - State IDLE, streak 0, beat 0.
  - All outputs 0, including fill_rdata_o.
  - Reset mid-burst abandons the burst. A line already yumi'd is dropped; this is acceptable because reset is global.
- Write latency: grant cycle, then ≥4 cycles of beats, then return to IDLE.
  - Zero-stall burst: grant at cycle T; beats at T+1..T+4; IDLE at T+5.
  - The next grant can occur at T+5.
- Read latency: grant at T; request at T+1 (if ready); beats arrive at any spacing; fill_resp_o the cycle after beat 3.
- fill_read_i dropping before fill_resp_o is illegal (assertion in the bench).
- Simultaneous full EWB and pending fill: the write wins regardless of streak.
- A fill arriving while a write is in flight waits; the grant is re-evaluated in IDLE.
- streak saturates at READ_PRIO_MAX; it never wraps.

## Test plan
- Reset, then idle inputs -> all outputs 0 for 10 cycles; no grant.
- EWB holds one line, data=256'h...0403020100 pattern, addr=32'h0000_1234, ready always 1 -> ewb_yumi_o at T; 4 write beats at T+1..T+4; bmem_addr_o=32'h0000_1220; beat 0 = line[63:0].
- Fill at addr 32'h0000_8000, rvalid beats D0..D3 with 2-cycle gaps -> one request cycle; fill_resp_o once with fill_rdata_o={D3,D2,D1,D0}.
- Fill continuously pending, EWB non-empty and not full, READ_PRIO_MAX=4 -> 4 read grants, then 1 write grant, then reads resume.
- EWB full and fill pending in the same IDLE cycle -> write granted first; read follows.
- bmem_ready_i low for 3 cycles during write beat 2 -> beat 2 data and address held stable; burst completes with 4 accepted beats. Repeat with rst asserted mid-burst -> all outputs 0 next cycle, state IDLE.
